// File: rtl/branch_predecode_pkg.sv
// Shared RV32I decode helpers and default sizing for the branch predecoder.
package rv32i_types;
    localparam logic [6:0] op_b_jal  = 7'b1101111;
    localparam logic [6:0] op_b_jalr = 7'b1100111;
    localparam logic [6:0] op_b_br   = 7'b1100011;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction
endpackage

package params;
    localparam int BHT_DEPTH_DEF = 64;
    localparam int RAS_DEPTH_DEF = 8;
endpackage

// File: rtl/branch_predecode_ras.sv
// Circular return-address stack; only built when BRID_RAS_EN is defined.
`ifdef BRID_RAS_EN
module return_addr_stack #(
    parameter int DEPTH = params::RAS_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_addr,
    output logic [31:0] top,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] ONE  = 1;
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_m1;
    logic [PW:0]   cnt;
    logic          pop_eff;

    assign ptr_m1  = ptr - ONE;
    assign empty   = (cnt == '0);
    assign top     = mem[ptr_m1];
    assign pop_eff = pop && !empty;

    // Entries are deliberately left unreset; count/pointer alone define validity.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push && pop_eff)
                mem[ptr_m1] <= push_addr;
            else if (push)
                mem[ptr] <= push_addr;
        end
    end

    // When full, ptr already addresses the oldest entry, so a push overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (flush) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push && pop_eff) begin
            ptr <= ptr;
        end else if (push) begin
            ptr <= ptr + ONE;
            if (cnt != FULL)
                cnt <= cnt + 1'b1;
        end else if (pop_eff) begin
            ptr <= ptr_m1;
            cnt <= cnt - 1'b1;
        end
    end
endmodule
`endif

// File: rtl/branch_predecode.sv
// Zero-latency fetch-side branch predictor: BHT for conditionals, JAL always taken,
// optional return-address stack enabled by BRID_RAS_EN.
module branch_predecode
    import rv32i_types::*;
#(
    parameter int BHT_DEPTH = params::BHT_DEPTH_DEF,
    parameter int RAS_DEPTH = params::RAS_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_enqueue,
    input  logic [31:0] iq_wdata,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        bp_is_taken,
    output logic [31:0] pc_br_brid
);
    localparam int IW = $clog2(BHT_DEPTH);

    logic [1:0]    bht [BHT_DEPTH];
    logic [IW-1:0] pred_idx;
    logic [IW-1:0] upd_idx;
    logic [6:0]    opcode;
    logic          taken;
    logic [31:0]   target;
    logic          unused_upd_bits;

    assign opcode          = iq_wdata[6:0];
    assign pred_idx        = pc[IW+1:2];
    assign upd_idx         = upd_pc[IW+1:2];
    assign unused_upd_bits = ^{upd_pc[31:IW+2], upd_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken && bht[upd_idx] != 2'b11)
                bht[upd_idx] <= bht[upd_idx] + 2'b01;
            else if (!upd_taken && bht[upd_idx] != 2'b00)
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
        end
    end

`ifdef BRID_RAS_EN
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        rd_l;
    logic        rs_l;

    assign rd_l = is_link(iq_wdata[11:7]);
    assign rs_l = is_link(iq_wdata[19:15]);

    return_addr_stack #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (flush),
        .push_addr (pc + 32'd4),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`endif

    // flush suppresses both the prediction and any stack movement this cycle.
    always_comb begin
        taken  = 1'b0;
        target = '0;
`ifdef BRID_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        if (fetch_enqueue && !flush) begin
            case (opcode)
                op_b_jal: begin
                    taken  = 1'b1;
                    target = (pc + imm_j(iq_wdata)) & ~32'd1;
`ifdef BRID_RAS_EN
                    ras_push = rd_l;
`endif
                end
                op_b_br: begin
                    if (bht[pred_idx][1]) begin
                        taken  = 1'b1;
                        target = pc + imm_b(iq_wdata);
                    end
                end
                op_b_jalr: begin
`ifdef BRID_RAS_EN
                    if (rd_l && rs_l && iq_wdata[19:15] == iq_wdata[11:7]) begin
                        ras_push = 1'b1;
                    end else begin
                        if (rs_l && !ras_empty) begin
                            taken   = 1'b1;
                            target  = ras_top & ~32'd1;
                            ras_pop = 1'b1;
                        end
                        ras_push = rd_l;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign bp_is_taken = taken;
    assign pc_br_brid  = target;
endmodule

// File: tb/tb_branch_predecode.sv
// Directed self-checking bench for branch_predecode; RAS cases follow BRID_RAS_EN.
module tb_branch_predecode;
    localparam logic [31:0] BR   = 32'h0200_0063; // beq x0,x0,+0x20
    localparam logic [31:0] JAL1 = 32'h1000_00EF; // jal x1,+0x100
    localparam logic [31:0] JNEG = 32'hFFDF_F06F; // jal x0,-4
    localparam logic [31:0] RET  = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] CORO = 32'h0002_80E7; // jalr x1,0(x5)

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_enqueue;
    logic [31:0] iq_wdata;
    logic [31:0] pc;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        bp_is_taken;
    logic [31:0] pc_br_brid;

    int n_chk  = 0;
    int n_pass = 0;

    branch_predecode dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_enqueue (fetch_enqueue),
        .iq_wdata      (iq_wdata),
        .pc            (pc),
        .flush         (flush),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .bp_is_taken   (bp_is_taken),
        .pc_br_brid    (pc_br_brid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle();
        fetch_enqueue = 1'b0;
        iq_wdata      = '0;
        pc            = '0;
        flush         = 1'b0;
        upd_valid     = 1'b0;
        upd_pc        = '0;
        upd_taken     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic set_upd(input logic [31:0] a, input logic tk);
        upd_valid = 1'b1;
        upd_pc    = a;
        upd_taken = tk;
    endtask

    task automatic upd(input logic [31:0] a, input logic tk);
        set_upd(a, tk);
        tick();
    endtask

    // Present one fetch, check the combinational prediction, then clock it in.
    task automatic pred(input string tag, input logic [31:0] inst, input logic [31:0] a,
                        input logic t, input logic [31:0] tgt);
        fetch_enqueue = 1'b1;
        iq_wdata      = inst;
        pc            = a;
        #1;
        chk({tag, ".taken"}, {31'd0, bp_is_taken}, {31'd0, t});
        chk({tag, ".target"}, pc_br_brid, tgt);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.taken", {31'd0, bp_is_taken}, 32'd0);
        chk("rst.target", pc_br_brid, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        pred("br_cold", BR, 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b1);
        upd(32'h100, 1'b1);
        pred("br_hot", BR, 32'h100, 1'b1, 32'h120);

        iq_wdata = BR;
        pc       = 32'h100;
        #1;
        chk("no_enq.taken", {31'd0, bp_is_taken}, 32'd0);
        chk("no_enq.target", pc_br_brid, 32'd0);
        tick();

        pred("jal_neg", JNEG, 32'h500, 1'b1, 32'h4FC);

        // Counter at 3: saturate, then same-cycle predictions see the old value.
        set_upd(32'h100, 1'b1);
        pred("sat3", BR, 32'h100, 1'b1, 32'h120);
        set_upd(32'h100, 1'b0);
        pred("old3", BR, 32'h100, 1'b1, 32'h120);
        set_upd(32'h100, 1'b0);
        pred("old2", BR, 32'h100, 1'b1, 32'h120);
        pred("cnt1", BR, 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0);
        upd(32'h100, 1'b0);
        upd(32'h100, 1'b1);
        pred("cnt0_hold", BR, 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b1);
        pred("cnt2", BR, 32'h100, 1'b1, 32'h120);
        upd(32'h100, 1'b1);

        // Asynchronous reset in the middle of a cycle with a fetch present.
        fetch_enqueue = 1'b1;
        iq_wdata      = BR;
        pc            = 32'h100;
        #1;
        chk("pre_rst.taken", {31'd0, bp_is_taken}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst.taken", {31'd0, bp_is_taken}, 32'd0);
        chk("mid_rst.target", pc_br_brid, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        pred("post_rst", BR, 32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b1);
        pred("post_rst_wk", BR, 32'h100, 1'b1, 32'h120);

        // flush zeroes outputs but the BHT update still lands.
        flush = 1'b1;
        set_upd(32'h180, 1'b1);
        pred("fl_br", BR, 32'h180, 1'b0, 32'h0);
        pred("fl_br_upd", BR, 32'h180, 1'b1, 32'h1A0);

        pred("call", JAL1, 32'h200, 1'b1, 32'h300);
`ifdef BRID_RAS_EN
        pred("ret", RET, 32'h400, 1'b1, 32'h204);
        pred("ret_empty", RET, 32'h404, 1'b0, 32'h0);

        for (int k = 0; k < 9; k++)
            pred($sformatf("call%0d", k), JAL1, 32'h1000 + 32'(4 * k), 1'b1, 32'h1100 + 32'(4 * k));
        for (int k = 0; k < 8; k++)
            pred($sformatf("ret%0d", k), RET, 32'h2000, 1'b1, 32'h1024 - 32'(4 * k));
        pred("ret8_empty", RET, 32'h2000, 1'b0, 32'h0);

        pred("call_fl", JAL1, 32'h3000, 1'b1, 32'h3100);
        flush = 1'b1;
        pred("ret_fl", RET, 32'h3100, 1'b0, 32'h0);
        pred("ret_after_fl", RET, 32'h3104, 1'b0, 32'h0);

        pred("call_co", JAL1, 32'h3200, 1'b1, 32'h3300);
        pred("coro", CORO, 32'h3300, 1'b1, 32'h3204);
        pred("ret_co", RET, 32'h3400, 1'b1, 32'h3304);
        pred("ret_co_empty", RET, 32'h3404, 1'b0, 32'h0);
`else
        pred("ret_nor", RET, 32'h400, 1'b0, 32'h0);
        pred("coro_nor", CORO, 32'h404, 1'b0, 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/branch_predecode.md
BRANCH_PREDECODE -- requirements
Module: branch_predecode

Interface
REQ-001 Parameter BHT_DEPTH, default 64: number of 2-bit conditional-branch counters; power of two, at least 4.
REQ-002 Parameter RAS_DEPTH, default 8: number of return-address-stack entries; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fetch_enqueue  input  1  instruction word is valid and being written to the instruction queue this cycle.
REQ-006 iq_wdata  input  32  fetched instruction word.
REQ-007 pc  input  32  address of iq_wdata.
REQ-008 flush  input  1  pipeline redirect; discards speculative RAS state.
REQ-009 upd_valid  input  1  resolved conditional branch from commit.
REQ-010 upd_pc  input  32  PC of the resolved branch.
REQ-011 upd_taken  input  1  resolved direction.
REQ-012 bp_is_taken  output  1  fetch redirects to pc_br_brid.
REQ-013 pc_br_brid  output  32  predicted target.

Function
REQ-014 Prediction is combinational, with zero latency, from fetch_enqueue, iq_wdata, pc and current state; when no prediction is made, bp_is_taken=0 and pc_br_brid=0.
REQ-015 JAL: taken; target = (pc + J-immediate) with bit0 cleared.
REQ-016 Conditional branch (opcode 1100011): taken iff BHT[pc[log2(BHT_DEPTH)+1:2]] >= 2; target = pc + B-immediate.
REQ-017 Link register means rd or rs1 equal to x1 or x5.
REQ-018 Call (JAL or JALR with rd link): push pc+4 at the next edge.
REQ-019 Return (JALR with rs1 link, rd not link): if the RAS is non-empty, predict taken to the top entry with bit0 cleared and pop; if empty, predict not taken and leave the RAS unchanged.
REQ-020 JALR with rd link and rs1 link, rs1 != rd: predict taken to the top entry (if non-empty), then pop and push pc+4 in one cycle; with rs1 == rd: push only, with no return prediction.
REQ-021 Other JALR: not taken.
REQ-022 RAS is circular: a push when full overwrites the oldest entry and count stays RAS_DEPTH.
REQ-023 upd_valid: the counter at upd_pc index saturates up (taken) or down (not taken) at the next edge; 3 and 0 hold.
REQ-024 Prediction and update to the same index in the same cycle: the prediction uses the pre-update value.
REQ-025 flush: RAS count and pointer go to 0 at the next edge; the same cycle's outputs are forced to 0 and no push or pop occurs; BHT update still applies.

Reset
REQ-026 rst asserted at any time, including mid-operation: all BHT counters become 01 (weakly not-taken), RAS count becomes 0, RAS pointer becomes 0, and the outputs follow REQ-014 immediately.
REQ-027 RAS entry contents are not reset.

Configuration
REQ-028 Macro BRID_RAS_EN: when defined, the RAS and REQ-017..022 are present.
REQ-029 When BRID_RAS_EN is undefined, there is no RAS storage, every JALR predicts not taken, and a JAL still predicts taken with no push.

Structure
REQ-030 Opcode constants (op_b_jal, op_b_jalr, op_b_br), the link-register check, and the immediate-extraction functions belong in the shared rv32i_types package.
REQ-031 BHT_DEPTH and RAS_DEPTH defaults belong in the params package.
REQ-032 The RAS is a sub-module named return_addr_stack (push, pop, flush, top, empty).

Verification
REQ-033 Reset, then a branch at pc=0x100 with offset +0x20 -> not taken; after two taken updates at 0x100, the same branch -> taken, pc_br_brid=0x120.
REQ-034 JAL x1 at pc=0x200, then JALR x0,0(x1) at 0x400 -> the second predicts taken with pc_br_brid=0x204, and the RAS is empty afterwards.
REQ-035 With RAS_DEPTH=8, do 9 calls from pc=0x1000+4k (k=0..8), then 9 returns -> the first 8 return 0x1024 down to 0x1008; the 9th predicts not taken.
REQ-036 Return asserted in the same cycle as flush -> outputs 0, the RAS is cleared, and the next return predicts not taken.
REQ-037 Counter at 3 with upd_taken=1 -> stays 3; prediction at the same index in the update cycle sees the old value; assert rst mid-sequence -> counter 01.
REQ-038 Build without BRID_RAS_EN and repeat REQ-034 -> the JALR predicts not taken.
